from_dec: RTL and testbench
===========================

FROM_DEC -- requirements
Module: from_dec

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 3, meaning the maximum number of decimal digits accepted per number.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port char_in  input  8  ASCII character from the upstream source.
REQ-005 SHALL have port char_valid  input  1  char_in holds a character to consume.
REQ-006 SHALL have port char_ready  output  1  block can accept a character this cycle.
REQ-007 SHALL have port value  output  8  parsed binary result, held until the next result.
REQ-008 SHALL have port value_valid  output  1  one-cycle pulse marking a new value.
REQ-009 SHALL have port overflow  output  1  last result saturated; updated with value.

Function
REQ-010 SHALL accept a character only on a cycle where char_valid and char_ready are both 1; other cycles consume nothing, and the held char_in is re-presented.
REQ-011 SHALL classify a character as a digit iff 8'h30 <= char_in <= 8'h39; digit weight = char_in - 8'h30.
REQ-012 SHALL implement states IDLE, DIGIT, MUL, DONE; char_ready = 1 in IDLE and DIGIT, 0 in MUL and DONE.
REQ-013 In IDLE, a non-digit SHALL be consumed and discarded, staying in IDLE; a digit SHALL be latched, with digit count cleared and accumulator at 0, moving to MUL.
REQ-014 In MUL (exactly one cycle), the 10-bit accumulator SHALL become acc*10 + digit (shift-add: acc<<3 + acc<<1 + d), the digit count SHALL increment, and the state SHALL go to DIGIT.
REQ-015 In DIGIT, a digit SHALL go to MUL; a non-digit SHALL be consumed as the terminator and go to DONE.
REQ-016 A digit arriving when the count already equals MAX_DIGITS SHALL set a sticky over flag, leave the accumulator unchanged, and be consumed; it SHALL NOT cause a MUL cycle.
REQ-017 In DONE (one cycle), value_valid SHALL be 1; value = 8'd255 and overflow = 1 if over flag set or acc > 255; otherwise value = acc[7:0] and overflow = 0; next state IDLE.
REQ-018 Leading zeros SHALL count as digits ("007" -> 7; "0007" with MAX_DIGITS=3 -> overflow).
REQ-019 Throughput SHALL be 2 cycles per digit; latency from terminator acceptance to value_valid SHALL be exactly 1 cycle.
REQ-020 value and overflow SHALL change only in DONE and hold between results.
REQ-021 Accumulator arithmetic SHALL be 10 bits wide (max 999) with no intermediate truncation.

Reset
REQ-022 rst_n low SHALL immediately force state IDLE, accumulator 0, count 0, over flag 0, value 0, value_valid 0, overflow 0; char_ready follows IDLE (1) once rst_n is high.
REQ-023 Reset mid-number SHALL discard the partial number with no value_valid pulse.

Structure
REQ-024 State encodings and the ASCII constants (CHAR_0 = 8'h30, CHAR_9 = 8'h39) SHALL live in a shared package.
REQ-025 No sub-module SHALL be used; digit classification and multiply-by-10 are inline in a single module.

Verification
REQ-026 Send "123\n" with char_valid held continuously -> exactly one value_valid pulse, value=123, overflow=0, char_ready low on each MUL cycle.
REQ-027 Send "255 " then "256 " -> value=255 with overflow=0, then value=255 with overflow=1.
REQ-028 Send "1234," -> value=255, overflow=1, accumulator never exceeds 123; send "0007;" -> overflow=1.
REQ-029 Send " x\r" (non-digits only) -> no value_valid; block stays in IDLE with char_ready=1 throughout.
REQ-030 Send "4" then "5" with char_valid gaps of 3 idle cycles, then "\n" -> value=45; each char consumed exactly once.
REQ-031 Send "98" then assert rst_n low for 1 cycle, then send "7\n" -> no pulse for 98; next pulse value=7, overflow=0.

Source files
------------

// File: rtl/from_dec_pkg.sv
// Shared definitions for the ASCII decimal-to-binary parser: state encoding,
// character constants and the digit classifier.
package from_dec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIGIT = 2'd1,
    MUL   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] CHAR_0 = 8'h30;
  localparam logic [7:0] CHAR_9 = 8'h39;
  localparam int         ACC_W  = 10;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CHAR_0) && (c <= CHAR_9);
  endfunction

endpackage

// File: rtl/from_dec_if.sv
// Character input handshake plus parsed-result outputs of from_dec.
interface from_dec_if;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic [7:0] value;
  logic       value_valid;
  logic       overflow;

  modport master (
    output char_in, char_valid,
    input  char_ready, value, value_valid, overflow
  );

  modport slave (
    input  char_in, char_valid,
    output char_ready, value, value_valid, overflow
  );
endinterface

// File: rtl/from_dec.sv
// Parses a stream of ASCII decimal digits terminated by any non-digit into an
// 8-bit saturating binary value, one multiply-by-10 cycle per digit.
module from_dec
  import from_dec_pkg::*;
#(
  parameter int MAX_DIGITS = 3
) (
  input  logic     clk,
  input  logic     rst_n,
  from_dec_if.slave bus
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [3:0]       digit_q;
  logic [CW-1:0]    count;
  logic             over;

  logic             accept;
  logic             in_digit;
  logic [ACC_W-1:0] acc_mul;

  assign bus.char_ready = (state == IDLE) || (state == DIGIT);
  assign accept         = bus.char_valid && bus.char_ready;
  assign in_digit       = is_digit(bus.char_in);
  // acc*10 + d as shift-add; acc is at most 99 here so 990 fits in 10 bits
  assign acc_mul        = (acc << 3) + (acc << 1) + {{(ACC_W-4){1'b0}}, digit_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      acc             <= '0;
      digit_q         <= '0;
      count           <= '0;
      over            <= 1'b0;
      bus.value       <= '0;
      bus.value_valid <= 1'b0;
      bus.overflow    <= 1'b0;
    end else begin
      bus.value_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && in_digit) begin
            // low nibble of '0'..'9' is the digit weight
            digit_q <= bus.char_in[3:0];
            count   <= '0;
            acc     <= '0;
            over    <= 1'b0;
            state   <= MUL;
          end
        end
        MUL: begin
          acc   <= acc_mul;
          count <= count + CW'(1);
          state <= DIGIT;
        end
        DIGIT: begin
          if (accept) begin
            if (in_digit) begin
              if (count == CW'(MAX_DIGITS)) begin
                over <= 1'b1;
              end else begin
                digit_q <= bus.char_in[3:0];
                state   <= MUL;
              end
            end else begin
              // result registered on the terminator so it is visible during DONE
              bus.value_valid <= 1'b1;
              if (over || (acc > ACC_W'(255))) begin
                bus.value    <= 8'd255;
                bus.overflow <= 1'b1;
              end else begin
                bus.value    <= acc[7:0];
                bus.overflow <= 1'b0;
              end
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_from_dec.sv
// Self-checking bench for from_dec: directed strings followed by random
// numbers, checked against an integer-level parsing model.
module tb_from_dec;

  localparam int MAXD = 3;

  logic clk = 1'b0;
  logic rst_n;

  from_dec_if bus ();

  from_dec #(.MAX_DIGITS(MAXD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model state: number in progress and queue of expected results
  bit         in_num;
  int         ndig;
  int         macc;
  bit         movr;
  logic [8:0] exp_q[$];
  logic [8:0] last_res;

  // Expectations for the negedge right after a character is consumed
  bit   pend;
  logic exp_ready;
  logic exp_vv;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    in_num   = 0;
    ndig     = 0;
    macc     = 0;
    movr     = 0;
    exp_q.delete();
    last_res = '0;
    pend     = 0;
  endtask

  task automatic model_char(input logic [7:0] c, output logic er, output logic ev);
    int d;
    er = 1'b1;
    ev = 1'b0;
    if (c >= 8'h30 && c <= 8'h39) begin
      d = int'(c) - 48;
      if (!in_num) begin
        in_num = 1; ndig = 1; macc = d; movr = 0; er = 1'b0;
      end else if (ndig == MAXD) begin
        movr = 1;
      end else begin
        macc = macc * 10 + d; ndig++; er = 1'b0;
      end
    end else if (in_num) begin
      exp_q.push_back((movr || macc > 255) ? 9'h1FF : 9'(macc));
      in_num = 0; er = 1'b0; ev = 1'b1;
    end
  endtask

  task automatic send_char(input logic [7:0] c, input int gap);
    int   n;
    logic er, ev;
    bus.char_in    = c;
    bus.char_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.char_ready && n < 50);
    if (!bus.char_ready) begin
      chk("ready_timeout", {15'd0, bus.char_ready}, 16'd1);
      $fatal(1, "char_ready never asserted");
    end
    @(posedge clk);
    #1;
    model_char(c, er, ev);
    exp_ready = er;
    exp_vv    = ev;
    pend      = 1;
    if (gap > 0) begin
      bus.char_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send_char(s[i], gap);
    bus.char_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.char_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Result/handshake monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (pend) begin
        chk("ready_after_accept", {15'd0, bus.char_ready}, {15'd0, exp_ready});
        chk("valid_latency", {15'd0, bus.value_valid}, {15'd0, exp_vv});
        pend = 0;
      end
      if (bus.value_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_pulse", {15'd0, bus.value_valid}, 16'd0);
        end else begin
          last_res = exp_q.pop_front();
          chk("value", {8'd0, bus.value}, {8'd0, last_res[7:0]});
          chk("overflow", {15'd0, bus.overflow}, {15'd0, last_res[8]});
        end
      end else begin
        chk("hold_value", {8'd0, bus.value}, {8'd0, last_res[7:0]});
        chk("hold_overflow", {15'd0, bus.overflow}, {15'd0, last_res[8]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] terms [7] = '{8'h20, 8'h0A, 8'h2C, 8'h3B, 8'h78, 8'h2F, 8'h3A};

  initial begin
    model_reset();
    rst_n          = 1'b0;
    bus.char_in    = '0;
    bus.char_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", {15'd0, bus.char_ready}, 16'd1);
    chk("reset_valid", {15'd0, bus.value_valid}, 16'd0);
    chk("reset_value", {8'd0, bus.value}, 16'd0);
    chk("reset_overflow", {15'd0, bus.overflow}, 16'd0);
    @(posedge clk);
    #1;

    send_str("123\n", 0);   idle(4);
    send_str("255 ", 0);    idle(3);
    send_str("256 ", 0);    idle(3);
    send_str("1234,", 0);   idle(3);
    send_str("0007;", 0);   idle(3);
    send_str("007 ", 0);    idle(3);
    send_str(" x\r", 0);    idle(3);
    send_str("45\n", 3);    idle(3);

    // Reset in the middle of a number discards it
    send_str("98", 0);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_str("7\n", 0);     idle(3);

    // Random numbers with random prefixes, terminators and valid gaps
    for (int k = 0; k < 40; k++) begin
      int nd;
      if ($urandom_range(0, 3) == 0) send_char(terms[$urandom_range(0, 6)], $urandom_range(0, 2));
      nd = $urandom_range(1, 5);
      for (int j = 0; j < nd; j++)
        send_char(8'h30 + 8'($urandom_range(0, 9)), $urandom_range(0, 2));
      send_char(terms[$urandom_range(0, 6)], $urandom_range(0, 2));
      bus.char_valid = 1'b0;
    end
    idle(5);

    chk("results_outstanding", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
